// File: rtl/gf180mcu_osu_tie_pkg.sv
// Shared types and sizing helpers for the programmable tie bank.
// Lock states, counter width and the WIDTH legality guard.
`ifndef GF180MCU_OSU_TIE_PKG_SV
`define GF180MCU_OSU_TIE_PKG_SV

`define TIE_WIDTH_CHECK(w) \
    if ((w) < 1 || (w) > 64) begin : g_bad_width \
        $error("gf180mcu_osu_tie: WIDTH out of range 1..64"); \
    end

package gf180mcu_osu_tie_pkg;

    typedef enum logic {
        TB_UNLOCKED = 1'b0,
        TB_LOCKED   = 1'b1
    } lock_state_e;

    function automatic int tie_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`endif

// File: rtl/gf180mcu_osu_tie_shreg.sv
// Serial config shift register with a saturating shift counter.
// The counter reports full once WIDTH bits have been shifted in.
module gf180mcu_osu_tie_shreg
    import gf180mcu_osu_tie_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] TIE_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_i,
    input  logic             si_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] shreg_o,
    output logic             cnt_full_o
);

    localparam int CNT_W = tie_cnt_w(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;

    if (WIDTH == 1) begin : g_w1
        assign shifted = si_i;
    end else begin : g_wn
        assign shifted = {shreg_q[WIDTH-2:0], si_i};
    end

    assign full = (cnt_q == CNT_W'(WIDTH));

    // A shift wins over clear so a colliding commit keeps counting.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (shift_i) begin
            shreg_d = shifted;
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clear_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= TIE_VAL;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign shreg_o    = shreg_q;
    assign cnt_full_o = full;

endmodule

// File: rtl/gf180mcu_osu_tie_bank.sv
// Programmable tie-high/tie-low bank with serial load, commit and lock.
// Y only moves at reset or on an accepted full-length commit.
module gf180mcu_osu_tie_bank
    import gf180mcu_osu_tie_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] TIE_VAL = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SI,
    input  logic             SEN,
    input  logic             UPD,
    input  logic             LOCK_REQ,
    output logic [WIDTH-1:0] Y,
    output logic             SO,
    output logic             ERR,
    output logic             LOCKED
);

    `TIE_WIDTH_CHECK(WIDTH)

    lock_state_e      state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] shreg;
    logic             cnt_full;
    logic             unlocked;
    logic             shift;
    logic             commit;
    logic             accept;

    assign unlocked = (state_q == TB_UNLOCKED);
    assign shift    = unlocked & SEN;
    assign commit   = unlocked & UPD & ~SEN;
    assign accept   = commit & cnt_full;

    gf180mcu_osu_tie_shreg #(
        .WIDTH   (WIDTH),
        .TIE_VAL (TIE_VAL)
    ) u_shreg (
        .clk_i      (CLK),
        .rst_i      (RST),
        .shift_i    (shift),
        .si_i       (SI),
        .clear_i    (commit),
        .shreg_o    (shreg),
        .cnt_full_o (cnt_full)
    );

    // Any UPD that is not accepted (short, collision, locked) flags ERR.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        err_d   = err_q;
        if (accept) begin
            y_d = shreg;
        end
        if (UPD) begin
            err_d = ~accept;
        end
        if (unlocked && LOCK_REQ) begin
            state_d = TB_LOCKED;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= TB_UNLOCKED;
            y_q     <= TIE_VAL;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign Y      = y_q;
    assign SO     = shreg[WIDTH-1];
    assign ERR    = err_q;
    assign LOCKED = (state_q == TB_LOCKED);

endmodule

// File: tb/tb_gf180mcu_osu_tie_bank.sv
// Directed bench for the tie bank: WIDTH=4 main build plus a WIDTH=1 build.
// Both instances share clock and inputs.
module tb_gf180mcu_osu_tie_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       si  = 1'b0;
    logic       sen = 1'b0;
    logic       upd = 1'b0;
    logic       lreq = 1'b0;
    logic [3:0] y;
    logic       so, err, locked;
    logic [0:0] y1;
    logic       so1, err1, locked1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf180mcu_osu_tie_bank #(.WIDTH(4), .TIE_VAL(4'b1010)) dut (
        .CLK(clk), .RST(rst), .SI(si), .SEN(sen), .UPD(upd),
        .LOCK_REQ(lreq), .Y(y), .SO(so), .ERR(err), .LOCKED(locked)
    );

    gf180mcu_osu_tie_bank #(.WIDTH(1), .TIE_VAL(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .SI(si), .SEN(sen), .UPD(upd),
        .LOCK_REQ(lreq), .Y(y1), .SO(so1), .ERR(err1), .LOCKED(locked1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        si = 0; sen = 0; upd = 0; lreq = 0; rst = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    // Shift v[n-1] first down to v[0].
    task automatic shift_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            si = v[i]; sen = 1;
            step();
        end
        sen = 0; si = 0;
    endtask

    task automatic commit();
        upd = 1;
        step();
        upd = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (y !== 4'b1010) begin errors++; $display("FAIL reset_y got %b want 1010", y); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL reset_so got %b want 1", so); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    endtask

    task automatic test_good_program();
        do_reset();
        shift_bits(8'b0110, 4);
        checks++; if (y !== 4'b1010) begin errors++; $display("FAIL good_y_pre got %b want 1010", y); end
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL good_so got %b want 0", so); end
        commit();
        checks++; if (y !== 4'b0110) begin errors++; $display("FAIL good_y got %b want 0110", y); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL good_err got %b want 0", err); end
    endtask

    task automatic test_short_shift();
        do_reset();
        shift_bits(8'b000, 3);
        commit();
        checks++; if (y !== 4'b1010) begin errors++; $display("FAIL short_y got %b want 1010", y); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", err); end
        shift_bits(8'b1111, 4);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL short_err_sticky got %b want 1", err); end
        commit();
        checks++; if (y !== 4'b1111) begin errors++; $display("FAIL short_fix_y got %b want 1111", y); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL short_fix_err got %b want 0", err); end
    endtask

    task automatic test_collision();
        shift_bits(8'b0011, 4);
        si = 1; sen = 1; upd = 1;
        step();
        idle();
        checks++; if (y !== 4'b1111) begin errors++; $display("FAIL coll_y got %b want 1111", y); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL coll_err got %b want 1", err); end
        commit();
        checks++; if (y !== 4'b0111) begin errors++; $display("FAIL coll_next_y got %b want 0111", y); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL coll_next_err got %b want 0", err); end
    endtask

    task automatic test_overshift();
        do_reset();
        shift_bits(8'b110011, 6);
        commit();
        checks++; if (y !== 4'b0011) begin errors++; $display("FAIL over_y got %b want 0011", y); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL over_err got %b want 0", err); end
    endtask

    task automatic test_lock();
        do_reset();
        shift_bits(8'b0101, 4);
        upd = 1; lreq = 1;
        step();
        idle();
        checks++; if (y !== 4'b0101) begin errors++; $display("FAIL lock_commit_y got %b want 0101", y); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_state got %b want 1", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lock_commit_err got %b want 0", err); end
        shift_bits(8'b1111, 4);
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL lock_so got %b want 0", so); end
        commit();
        checks++; if (y !== 4'b0101) begin errors++; $display("FAIL lock_y got %b want 0101", y); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL lock_err got %b want 1", err); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_hold got %b want 1", locked); end
    endtask

    task automatic test_reset_lock_midshift();
        shift_bits(8'b11, 2);
        si = 1; sen = 1; rst = 1;
        step();
        idle();
        checks++; if (y !== 4'b1010) begin errors++; $display("FAIL rstlk_y got %b want 1010", y); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstlk_locked got %b want 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstlk_err got %b want 0", err); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL rstlk_so got %b want 1", so); end
        // Two unlocked shifts, reset, two more: count must restart from zero.
        shift_bits(8'b00, 2);
        rst = 1;
        step();
        idle();
        shift_bits(8'b00, 2);
        commit();
        checks++; if (y !== 4'b1010) begin errors++; $display("FAIL rstmid_y got %b want 1010", y); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rstmid_err got %b want 1", err); end
    endtask

    task automatic test_width1();
        do_reset();
        checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL w1_reset_y got %b want 1", y1); end
        shift_bits(8'b0, 1);
        checks++; if (so1 !== 1'b0) begin errors++; $display("FAIL w1_so got %b want 0", so1); end
        commit();
        checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL w1_y got %b want 0", y1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL w1_err got %b want 0", err1); end
    endtask

    initial begin
        idle();
        step();
        test_reset();
        test_good_program();
        test_short_shift();
        test_collision();
        test_overshift();
        test_lock();
        test_reset_lock_midshift();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
